// File: rtl/nf_wb_merge.sv
// Write-back merge stage: owns the register-file write port and arbitrates
// between in-order pipeline results and in-order returning load data.
module nf_wb_merge #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_wa,
    input  logic [31:0] pipe_wd,
    input  logic        ld_issue,
    input  logic [4:0]  ld_wa,
    input  logic        ld_rvalid,
    input  logic [31:0] ld_rdata,
    output logic [4:0]  wa3,
    output logic [31:0] wd3,
    output logic        we3,
    output logic [31:0] pend_mask,
    output logic        ld_full,
    output logic        ld_empty,
    output logic        prot_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] data_ok_q, data_ok_d;
    logic [DEPTH-1:0] killed_q, killed_d;
    logic [4:0]       wa_q   [DEPTH];
    logic [4:0]       wa_d   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rsp_ptr_q, rsp_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [4:0]  wa3_q, wa3_d;
    logic [31:0] wd3_q, wd3_d;
    logic        we3_q, we3_d;
    logic        prot_err_q, prot_err_d;

    logic        pw;
    logic        issue_ok;
    logic        rsp_ok;
    logic        head_ready;
    logic        pop;
    logic        ret_wr;
    logic [31:0] pend_c;

    assign ld_full  = (count_q == CW'(DEPTH));
    assign ld_empty = (count_q == CW'(0));

    // Next-state: kill, response capture, head retire, issue, write-port mux
    always_comb begin
        valid_d    = valid_q;
        data_ok_d  = data_ok_q;
        killed_d   = killed_q;
        wa_d       = wa_q;
        data_d     = data_q;
        wr_ptr_d   = wr_ptr_q;
        rsp_ptr_d  = rsp_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        wa3_d      = 5'd0;
        wd3_d      = 32'd0;
        we3_d      = 1'b0;

        pw         = pipe_we & (pipe_wa != 5'd0);
        issue_ok   = ld_issue & ~ld_full;
        rsp_ok     = ld_rvalid & valid_q[rsp_ptr_q] & ~data_ok_q[rsp_ptr_q];
        head_ready = valid_q[rd_ptr_q] & data_ok_q[rd_ptr_q];
        pop        = head_ready & (killed_q[rd_ptr_q] | ~pw);
        ret_wr     = head_ready & ~killed_q[rd_ptr_q] & ~pw;

        // A younger pipeline result supersedes any pending load to the same register
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (pw && valid_q[i] && (wa_q[i] == pipe_wa)) begin
                killed_d[i] = 1'b1;
            end
        end

        if (rsp_ok) begin
            data_d[rsp_ptr_q]    = ld_rdata;
            data_ok_d[rsp_ptr_q] = 1'b1;
            rsp_ptr_d            = rsp_ptr_q + PW'(1);
        end

        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end

        if (issue_ok) begin
            valid_d[wr_ptr_q]   = 1'b1;
            data_ok_d[wr_ptr_q] = 1'b0;
            killed_d[wr_ptr_q]  = (ld_wa == 5'd0);
            wa_d[wr_ptr_q]      = ld_wa;
            wr_ptr_d            = wr_ptr_q + PW'(1);
        end

        count_d    = count_q + CW'(issue_ok) - CW'(pop);
        prot_err_d = prot_err_q | (ld_issue & ld_full) | (ld_rvalid & ~rsp_ok);

        // Idle must present x0/0 because the register file bypasses wd3 on address match
        if (pw) begin
            wa3_d = pipe_wa;
            wd3_d = pipe_wd;
            we3_d = 1'b1;
        end else if (ret_wr) begin
            wa3_d = wa_q[rd_ptr_q];
            wd3_d = data_q[rd_ptr_q];
            we3_d = 1'b1;
        end
    end

    always_comb begin
        pend_c = 32'd0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !killed_q[i]) begin
                pend_c[wa_q[i]] = 1'b1;
            end
        end
        pend_c[0] = 1'b0;
    end

    assign pend_mask = pend_c;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q    <= '0;
            data_ok_q  <= '0;
            killed_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                wa_q[i]   <= 5'd0;
                data_q[i] <= 32'd0;
            end
            wr_ptr_q   <= '0;
            rsp_ptr_q  <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wa3_q      <= 5'd0;
            wd3_q      <= 32'd0;
            we3_q      <= 1'b0;
            prot_err_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            data_ok_q  <= data_ok_d;
            killed_q   <= killed_d;
            wa_q       <= wa_d;
            data_q     <= data_d;
            wr_ptr_q   <= wr_ptr_d;
            rsp_ptr_q  <= rsp_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wa3_q      <= wa3_d;
            wd3_q      <= wd3_d;
            we3_q      <= we3_d;
            prot_err_q <= prot_err_d;
        end
    end

    assign wa3      = wa3_q;
    assign wd3      = wd3_q;
    assign we3      = we3_q;
    assign prot_err = prot_err_q;

endmodule

// File: tb/tb_nf_wb_merge.sv
// Bench for nf_wb_merge: directed scenarios plus randomized traffic checked
// against a queue-based model of the pending-load buffer.
module tb_nf_wb_merge;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        resetn;
    logic        pipe_we;
    logic [4:0]  pipe_wa;
    logic [31:0] pipe_wd;
    logic        ld_issue;
    logic [4:0]  ld_wa;
    logic        ld_rvalid;
    logic [31:0] ld_rdata;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic        we3;
    logic [31:0] pend_mask;
    logic        ld_full;
    logic        ld_empty;
    logic        prot_err;

    int total;
    int bad;

    nf_wb_merge #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
        .ld_issue(ld_issue), .ld_wa(ld_wa),
        .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .wa3(wa3), .wd3(wd3), .we3(we3),
        .pend_mask(pend_mask), .ld_full(ld_full), .ld_empty(ld_empty),
        .prot_err(prot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending loads as an ordered queue of records
    typedef struct {
        logic [4:0]  wa;
        logic [31:0] data;
        bit          has;
        bit          killed;
    } ent_t;

    ent_t        mq[$];
    logic [4:0]  m_wa3;
    logic [31:0] m_wd3;
    logic        m_we3;
    logic        m_perr;

    function automatic void model_reset();
        mq.delete();
        m_wa3  = 5'd0;
        m_wd3  = 32'd0;
        m_we3  = 1'b0;
        m_perr = 1'b0;
    endfunction

    function automatic logic [31:0] model_pend();
        logic [31:0] m;
        m = 32'd0;
        foreach (mq[i]) if (!mq[i].killed) m[mq[i].wa] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    function automatic bit model_waiting();
        foreach (mq[i]) if (!mq[i].has) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_step();
        bit   pw, pop, wr, was_full;
        int   idx;
        ent_t hd, e;
        pw       = pipe_we && (pipe_wa != 5'd0);
        was_full = (mq.size() == DEPTH);
        pop = 1'b0;
        wr  = 1'b0;
        if (mq.size() > 0 && mq[0].has) begin
            hd = mq[0];
            if (hd.killed) pop = 1'b1;
            else if (!pw) begin
                pop = 1'b1;
                wr  = 1'b1;
            end
        end
        if (ld_rvalid) begin
            idx = -1;
            foreach (mq[i]) if (!mq[i].has && idx < 0) idx = i;
            if (idx >= 0) begin
                e = mq[idx];
                e.has = 1'b1;
                e.data = ld_rdata;
                mq[idx] = e;
            end else m_perr = 1'b1;
        end
        if (pw) begin
            foreach (mq[i]) begin
                if (mq[i].wa == pipe_wa) begin
                    e = mq[i];
                    e.killed = 1'b1;
                    mq[i] = e;
                end
            end
        end
        if (pw) begin
            m_wa3 = pipe_wa; m_wd3 = pipe_wd; m_we3 = 1'b1;
        end else if (wr) begin
            m_wa3 = hd.wa; m_wd3 = hd.data; m_we3 = 1'b1;
        end else begin
            m_wa3 = 5'd0; m_wd3 = 32'd0; m_we3 = 1'b0;
        end
        if (pop) mq.delete(0);
        if (ld_issue) begin
            if (was_full) m_perr = 1'b1;
            else mq.push_back('{wa: ld_wa, data: 32'd0, has: 1'b0, killed: (ld_wa == 5'd0)});
        end
    endfunction

    task automatic tick(input logic pwe, input logic [4:0] pwa, input logic [31:0] pwd,
                        input logic iss, input logic [4:0] lwa,
                        input logic rv, input logic [31:0] rd);
        pipe_we = pwe; pipe_wa = pwa; pipe_wd = pwd;
        ld_issue = iss; ld_wa = lwa;
        ld_rvalid = rv; ld_rdata = rd;
        if (resetn) model_step();
        else model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        pipe_we = 1'b0; pipe_wa = 5'd0; pipe_wd = 32'd0;
        ld_issue = 1'b0; ld_wa = 5'd0; ld_rvalid = 1'b0; ld_rdata = 32'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (wa3 !== 5'd0 || wd3 !== 32'd0 || we3 !== 1'b0 || prot_err !== 1'b0 ||
            pend_mask !== 32'd0 || ld_empty !== 1'b1 || ld_full !== 1'b0) begin
            bad++;
            $display("FAIL reset: wa3=%0d wd3=%h we3=%b perr=%b pend=%h empty=%b full=%b, want all 0 empty=1",
                     wa3, wd3, we3, prot_err, pend_mask, ld_empty, ld_full);
        end
        resetn = 1'b1;
    endtask

    task automatic test_pipe_write();
        tick(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 32'd0);
        total++;
        if (wa3 !== 5'd5 || wd3 !== 32'hDEADBEEF || we3 !== 1'b1) begin
            bad++;
            $display("FAIL pipe_write: got %0d/%h/%b want 5/deadbeef/1", wa3, wd3, we3);
        end
        idle();
        total++;
        if (wa3 !== 5'd0 || wd3 !== 32'd0 || we3 !== 1'b0) begin
            bad++;
            $display("FAIL pipe_idle: got %0d/%h/%b want 0/0/0", wa3, wd3, we3);
        end
        tick(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0, 32'd0);
        total++;
        if (wa3 !== 5'd0 || wd3 !== 32'd0 || we3 !== 1'b0) begin
            bad++;
            $display("FAIL pipe_x0: got %0d/%h/%b want 0/0/0", wa3, wd3, we3);
        end
    endtask

    task automatic test_load_latency();
        tick(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 32'd0);
        total++;
        if (pend_mask !== 32'h80 || ld_empty !== 1'b0) begin
            bad++;
            $display("FAIL load_issue: pend=%h empty=%b want 80/0", pend_mask, ld_empty);
        end
        idle();
        tick(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h12345678);
        total++;
        if (we3 !== 1'b0 || pend_mask !== 32'h80) begin
            bad++;
            $display("FAIL load_n1: we3=%b pend=%h want 0/80", we3, pend_mask);
        end
        idle();
        total++;
        if (we3 !== 1'b1 || wa3 !== 5'd7 || wd3 !== 32'h12345678 || pend_mask !== 32'd0 || ld_empty !== 1'b1) begin
            bad++;
            $display("FAIL load_n2: %0d/%h/%b pend=%h empty=%b want 7/12345678/1 pend=0 empty=1",
                     wa3, wd3, we3, pend_mask, ld_empty);
        end
        idle();
        total++;
        if (we3 !== 1'b0 || wa3 !== 5'd0) begin
            bad++;
            $display("FAIL load_after: we3=%b wa3=%0d want 0/0", we3, wa3);
        end
    endtask

    task automatic test_pipe_priority();
        tick(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 32'd0);
        tick(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'hA5A5A5A5);
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 5'd3, 32'(k + 1), 1'b0, 5'd0, 1'b0, 32'd0);
            total++;
            if (wa3 !== 5'd3 || wd3 !== 32'(k + 1) || we3 !== 1'b1) begin
                bad++;
                $display("FAIL prio_pipe%0d: got %0d/%h/%b want 3/%h/1", k, wa3, wd3, we3, 32'(k + 1));
            end
        end
        idle();
        total++;
        if (wa3 !== 5'd7 || wd3 !== 32'hA5A5A5A5 || we3 !== 1'b1) begin
            bad++;
            $display("FAIL prio_load: got %0d/%h/%b want 7/a5a5a5a5/1", wa3, wd3, we3);
        end
        idle();
        total++;
        if (we3 !== 1'b0 || ld_empty !== 1'b1) begin
            bad++;
            $display("FAIL prio_done: we3=%b empty=%b want 0/1", we3, ld_empty);
        end
    endtask

    task automatic test_kill();
        tick(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 32'd0);
        idle();
        tick(1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 1'b0, 32'd0);
        total++;
        if (wa3 !== 5'd9 || wd3 !== 32'h1 || we3 !== 1'b1 || pend_mask[9] !== 1'b0) begin
            bad++;
            $display("FAIL kill_pipe: %0d/%h/%b pend=%h want 9/1/1 bit9=0", wa3, wd3, we3, pend_mask);
        end
        tick(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h00000BAD);
        for (int k = 0; k < 3; k++) begin
            idle();
            total++;
            if (we3 !== 1'b0 || wd3 !== 32'd0) begin
                bad++;
                $display("FAIL kill_nowrite%0d: we3=%b wa3=%0d wd3=%h want 0/0/0", k, we3, wa3, wd3);
            end
        end
        total++;
        if (ld_empty !== 1'b1 || prot_err !== 1'b0) begin
            bad++;
            $display("FAIL kill_pop: empty=%b perr=%b want 1/0", ld_empty, prot_err);
        end
    endtask

    task automatic test_full();
        logic [4:0]  got_wa[$];
        logic [31:0] got_wd[$];
        for (int i = 1; i <= 4; i++) tick(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 1'b0, 32'd0);
        total++;
        if (ld_full !== 1'b1 || pend_mask !== 32'h1E || prot_err !== 1'b0) begin
            bad++;
            $display("FAIL full_fill: full=%b pend=%h perr=%b want 1/1e/0", ld_full, pend_mask, prot_err);
        end
        tick(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 32'd0);
        total++;
        if (prot_err !== 1'b1 || pend_mask !== 32'h1E || ld_full !== 1'b1) begin
            bad++;
            $display("FAIL full_overflow: perr=%b pend=%h full=%b want 1/1e/1", prot_err, pend_mask, ld_full);
        end
        for (int k = 0; k < 7; k++) begin
            if (k < 4) tick(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h100 + 32'(k));
            else idle();
            if (we3) begin
                got_wa.push_back(wa3);
                got_wd.push_back(wd3);
            end
        end
        total++;
        if (got_wa.size() != 4) begin
            bad++;
            $display("FAIL full_count: writes=%0d want 4", got_wa.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (got_wa[k] !== 5'(k + 1) || got_wd[k] !== 32'h100 + 32'(k)) begin
                    bad++;
                    $display("FAIL full_order%0d: got %0d/%h want %0d/%h", k, got_wa[k], got_wd[k],
                             k + 1, 32'h100 + 32'(k));
                end
            end
        end
        total++;
        if (ld_empty !== 1'b1 || ld_full !== 1'b0) begin
            bad++;
            $display("FAIL full_drain: empty=%b full=%b want 1/0", ld_empty, ld_full);
        end
    endtask

    task automatic test_mid_reset();
        resetn = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        tick(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 1'b0, 32'd0);
        tick(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 1'b0, 32'd0);
        tick(1'b1, 5'd12, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0, 32'd0);
        total++;
        if (we3 !== 1'b1 || pend_mask !== 32'h0C00) begin
            bad++;
            $display("FAIL mrst_pre: we3=%b pend=%h want 1/c00", we3, pend_mask);
        end
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        total++;
        if (wa3 !== 5'd0 || wd3 !== 32'd0 || we3 !== 1'b0 || pend_mask !== 32'd0 ||
            ld_empty !== 1'b1 || prot_err !== 1'b0) begin
            bad++;
            $display("FAIL mrst_async: %0d/%h/%b pend=%h empty=%b perr=%b want all 0 empty=1",
                     wa3, wd3, we3, pend_mask, ld_empty, prot_err);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        tick(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h55);
        total++;
        if (prot_err !== 1'b1 || we3 !== 1'b0) begin
            bad++;
            $display("FAIL mrst_rsp: perr=%b we3=%b want 1/0", prot_err, we3);
        end
        tick(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h66);
        idle();
        total++;
        if (we3 !== 1'b0 || prot_err !== 1'b1 || ld_empty !== 1'b1) begin
            bad++;
            $display("FAIL mrst_after: we3=%b perr=%b empty=%b want 0/1/1", we3, prot_err, ld_empty);
        end
    endtask

    task automatic test_random();
        logic rv;
        int   shown;
        shown = 0;
        resetn = 1'b0;
        idle();
        resetn = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(99) == 0) begin
                resetn = 1'b0;
                idle();
                resetn = 1'b1;
            end else begin
                rv = model_waiting() ? ($urandom_range(99) < 50) : ($urandom_range(99) < 3);
                tick($urandom_range(99) < 40, 5'($urandom_range(7)), $urandom,
                     $urandom_range(99) < 35, 5'($urandom_range(7)), rv, $urandom);
            end
            total++;
            if (wa3 !== m_wa3 || wd3 !== m_wd3 || we3 !== m_we3 || prot_err !== m_perr ||
                pend_mask !== model_pend() || ld_full !== (mq.size() == DEPTH) ||
                ld_empty !== (mq.size() == 0)) begin
                bad++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random@%0d: got %0d/%h/%b perr=%b pend=%h full=%b empty=%b want %0d/%h/%b perr=%b pend=%h n=%0d",
                             n, wa3, wd3, we3, prot_err, pend_mask, ld_full, ld_empty,
                             m_wa3, m_wd3, m_we3, m_perr, model_pend(), mq.size());
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_pipe_write();
        test_load_latency();
        test_pipe_priority();
        test_kill();
        test_full();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nf_wb_merge.md
Name: nf_wb_merge

Overview:
- Write-back merge stage directly upstream of the core register file. It owns the file's single write port (wa3/wd3/we3).
- Merges two sources: in-order pipeline results, and out-of-band load data returning from the LSU. Load data is buffered in an in-order pending-load queue.
- Exports a pending-destination mask so the hazard unit can stall readers of registers whose load has not yet been written.

Parameters:
- DEPTH, 4, pending-load queue entries (power of two, >=2).
- PW, $clog2(DEPTH), pointer width (derived; not overridden).

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous active-low reset.
- pipe_we  in  1  pipeline write request this cycle.
- pipe_wa  in  5  pipeline destination register.
- pipe_wd  in  32  pipeline write data.
- ld_issue  in  1  load issued this cycle; allocates a queue entry.
- ld_wa  in  5  destination register of the issued load.
- ld_rvalid  in  1  load data returning (in issue order).
- ld_rdata  in  32  returned load data.
- wa3  out  5  register-file write address.
- wd3  out  32  register-file write data.
- we3  out  1  register-file write enable.
- pend_mask  out  32  bit r = live pending load targets xr.
- ld_full  out  1  queue full; issue must be held off.
- ld_empty  out  1  no entries allocated.
- prot_err  out  1  sticky protocol error.

Behaviour:
- Reset (async, resetn=0): all pointers and count 0, all entries invalid, wa3=0, wd3=0, we3=0, prot_err=0. Mid-operation reset drops all pending loads; no write is issued afterwards.
- Queue entry fields: valid, data_ok, killed, wa[4:0], data[31:0].
- Three pointers, each wrapping modulo DEPTH:
  - wr_ptr advances on issue.
  - rsp_ptr advances on response; it is the oldest entry without data.
  - rd_ptr advances on retire.
- Occupancy count is PW+1 bits. ld_full = (count==DEPTH); ld_empty = (count==0); both combinational from state.
- Issue:
  - ld_issue & !ld_full: write entry at wr_ptr (valid=1, data_ok=0, killed=(ld_wa==0)), then advance wr_ptr.
  - ld_issue & ld_full: ignored; prot_err<=1.
- Response:
  - ld_rvalid with an entry at rsp_ptr that is valid and !data_ok: store data, set data_ok, advance rsp_ptr.
  - ld_rvalid with no such entry: ignored; prot_err<=1.
- Effective pipeline write: pw = pipe_we & (pipe_wa!=0).
- Kill: when pw, every valid entry with wa==pipe_wa sets killed=1 (the pipeline result is younger). An entry issued in the same cycle is not killed.
- Retire is evaluated on head entry H = entry[rd_ptr]:
  - H valid & data_ok & killed: pop without writing, regardless of pw.
  - H valid & data_ok & !killed & !pw: pop, and write H.wa/H.data.
  - Otherwise no pop; the head waits, since the pipeline has priority.
- Outputs are registered, with write-port latency 1 cycle:
  - If pw: next wa3=pipe_wa, wd3=pipe_wd, we3=1.
  - Else if a load retires with a write: next wa3=H.wa, wd3=H.data, we3=1.
  - Else: wa3=0, wd3=0, we3=0. This is mandatory: the register file bypasses wd3 to any reader with ra==wa3 irrespective of we3, so idle must present x0/0.
- Pipeline writes to x0 and pipe_we=0 both produce the idle output (no x0 write, x0 bypass stays 0).
- Load latency: response captured in cycle N; earliest retire is cycle N+1; we3 is asserted in cycle N+2.
- Simultaneous issue, response and retire in one cycle are legal, including at full: retire frees nothing for a same-cycle issue, because the full check uses the registered count.
- pend_mask: combinational OR over valid & !killed entries of onehot(wa); bit 0 is always 0.
- prot_err stays set until reset.

Test Plan:
- Pipeline write x5=0xDEADBEEF -> next cycle wa3=5, wd3=0xDEADBEEF, we3=1; following idle cycle wa3=0, wd3=0, we3=0.
- Issue load to x7, response 0x12345678 two cycles later with no pipeline writes -> pend_mask=0x80 until retire; we3 asserted with wa3=7 exactly 2 cycles after ld_rvalid; pend_mask=0 afterwards.
- Load to x7 has data ready while the pipeline writes x3 for 3 consecutive cycles -> x3 written 3 times, then x7 written in the first pipeline-idle cycle.
- Load to x9 pending, pipeline writes x9=0x1 -> killed; pend_mask bit 9 clears; the later response pops with no write; only 0x1 ever reaches wd3 for x9.
- Issue 4 loads (DEPTH=4) to x1..x4 -> ld_full=1; a 5th issue sets prot_err=1 and is dropped; 4 responses retire in order x1..x4; ld_empty=1 at the end.
- Assert resetn=0 with 2 loads pending -> all outputs 0 immediately; post-reset responses set prot_err=1 and produce no writes.
